ram_dp_be: RTL and testbench

Parametrised simple dual-port RAM with one write port and one read port. It extends the basic we/re RAM with:
- per-byte write enables
- selectable read latency (1 or 2) with an `rd_valid` strobe
- write-first read-during-write forwarding
- an optional hardware clear sequence after reset, flagged by `busy`

It is the storage block behind the RAM driver/monitor environment and replaces the fixed-width RAM as the DUT.

---
 rtl/ram_pkg.sv | 33 +++
 rtl/ram_rd_pipe.sv | 55 +++++
 rtl/ram_dp_be.sv | 100 ++++++++++
 tb/tb_ram_dp_be.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types, default parameters and the byte-lane merge helper for ram_dp_be.
package ram_pkg;

  typedef enum logic {RAM_INIT, RAM_READY} ram_state_e;

  localparam int unsigned DEF_ADDR_WIDTH   = 4;
  localparam int unsigned DEF_DATA_WIDTH   = 16;
  localparam int unsigned DEF_BYTE_WIDTH   = 8;
  localparam int unsigned DEF_RD_LATENCY   = 1;
  localparam bit          DEF_CLEAR_ON_RST = 1'b1;

  // Widest word be_merge can handle; callers zero-extend into it and truncate back.
  localparam int unsigned MERGE_WIDTH = 256;
  localparam int unsigned MERGE_IDX_W = $clog2(MERGE_WIDTH);

  // Enabled lanes take din, the rest keep old_word; be bit k covers lane k.
  function automatic logic [MERGE_WIDTH-1:0] be_merge(
    input logic [MERGE_WIDTH-1:0] old_word,
    input logic [MERGE_WIDTH-1:0] din,
    input logic [MERGE_WIDTH-1:0] be,
    input int unsigned            byte_width
  );
    logic [MERGE_WIDTH-1:0] res;
    res = old_word;
    for (int unsigned i = 0; i < MERGE_WIDTH; i++) begin
      if (be[MERGE_IDX_W'(i / byte_width)]) begin
        res[MERGE_IDX_W'(i)] = din[MERGE_IDX_W'(i)];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-data output pipeline: one or two register stages carrying data plus valid,
// flushed synchronously by rst. Data registers only load on valid so rd_dout holds.
module ram_rd_pipe
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) s1_data <= in_data;
    end
  end

  if (RD_LATENCY == 1) begin : g_lat1
    assign out_valid = s1_valid;
    assign out_data  = s1_data;
  end else if (RD_LATENCY == 2) begin : g_lat2
    logic                  s2_valid;
    logic [DATA_WIDTH-1:0] s2_data;

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= s1_data;
      end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
  end else begin : g_bad_latency
    $error("ram_rd_pipe: RD_LATENCY must be 1 or 2");
    assign out_valid = 1'b0;
    assign out_data  = '0;
  end

endmodule

// File: rtl/ram_dp_be.sv
// Simple dual-port RAM with byte enables, write-first collision forwarding,
// 1/2-cycle registered read and an optional post-reset clear sequence.
module ram_dp_be
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned BYTE_WIDTH   = DEF_BYTE_WIDTH,
  parameter int unsigned RD_LATENCY   = DEF_RD_LATENCY,
  parameter bit          CLEAR_ON_RST = DEF_CLEAR_ON_RST
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             we,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_din,
  input  logic                             re,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic [DATA_WIDTH-1:0]            rd_dout,
  output logic                             rd_valid,
  output logic                             busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  if (BYTE_WIDTH == 0 || DATA_WIDTH % BYTE_WIDTH != 0 || DATA_WIDTH > MERGE_WIDTH)
  begin : g_bad_width
    $error("ram_dp_be: DATA_WIDTH must be a nonzero multiple of BYTE_WIDTH, at most %0d",
           MERGE_WIDTH);
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  ram_state_e            state, state_next;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  clr_we_c;
  logic                  wr_en_c;
  logic                  rd_en_c;
  logic [DATA_WIDTH-1:0] wr_word_c;
  logic [DATA_WIDTH-1:0] rd_word_c;

  // State, clear counter and busy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR_ON_RST ? RAM_INIT : RAM_READY;
      clr_cnt <= '0;
      busy    <= CLEAR_ON_RST;
    end else begin
      state <= state_next;
      busy  <= (state_next == RAM_INIT);
      if (clr_we_c) clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
    end
  end

  // Next state and port gating; user traffic only reaches memory in RAM_READY
  always_comb begin
    state_next = state;
    clr_we_c   = 1'b0;
    wr_en_c    = 1'b0;
    rd_en_c    = 1'b0;
    case (state)
      RAM_INIT: begin
        clr_we_c = !rst;
        if (clr_cnt == ADDR_WIDTH'(DEPTH - 1)) state_next = RAM_READY;
      end
      RAM_READY: begin
        wr_en_c = we && !rst;
        rd_en_c = re && !rst;
      end
      default: state_next = RAM_READY;
    endcase
  end

  // The merged write word doubles as the forwarded word on an address collision
  assign wr_word_c = DATA_WIDTH'(be_merge(MERGE_WIDTH'(mem[wr_addr]), MERGE_WIDTH'(wr_din),
                                          MERGE_WIDTH'(wr_be), BYTE_WIDTH));
  assign rd_word_c = (wr_en_c && (wr_addr == rd_addr)) ? wr_word_c : mem[rd_addr];

  always_ff @(posedge clk) begin
    if (clr_we_c) begin
      mem[clr_cnt] <= '0;
    end else if (wr_en_c) begin
      mem[wr_addr] <= wr_word_c;
    end
  end

  ram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_en_c),
    .in_data   (rd_word_c),
    .out_valid (rd_valid),
    .out_data  (rd_dout)
  );

endmodule

// File: tb/tb_ram_dp_be.sv
// Bench for ram_dp_be: three instances (latency 1 / latency 2 with clear, latency 2
// without clear) share one stimulus stream; expected values are hand-computed.
module tb_ram_dp_be;

  localparam int unsigned AW  = 4;
  localparam int unsigned DW  = 16;
  localparam int unsigned BW  = 8;
  localparam int unsigned NBE = DW / BW;

  typedef struct {
    logic           we;
    logic [NBE-1:0] be;
    logic [AW-1:0]  waddr;
    logic [DW-1:0]  din;
    logic           re;
    logic [AW-1:0]  raddr;
    logic           ev;
    logic [DW-1:0]  ed;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           we = 1'b0;
  logic           re = 1'b0;
  logic [NBE-1:0] wr_be = '0;
  logic [AW-1:0]  wr_addr = '0;
  logic [AW-1:0]  rd_addr = '0;
  logic [DW-1:0]  wr_din = '0;

  logic [DW-1:0] dout_l1, dout_l2, dout_nc;
  logic          v_l1, v_l2, v_nc, b_l1, b_l2, b_nc;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned busy_viol = 0;

  always #5 clk = ~clk;

  ram_dp_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW),
              .RD_LATENCY(1), .CLEAR_ON_RST(1'b1)) u_l1 (
    .clk(clk), .rst(rst), .we(we), .wr_be(wr_be), .wr_addr(wr_addr), .wr_din(wr_din),
    .re(re), .rd_addr(rd_addr), .rd_dout(dout_l1), .rd_valid(v_l1), .busy(b_l1));

  ram_dp_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW),
              .RD_LATENCY(2), .CLEAR_ON_RST(1'b1)) u_l2 (
    .clk(clk), .rst(rst), .we(we), .wr_be(wr_be), .wr_addr(wr_addr), .wr_din(wr_din),
    .re(re), .rd_addr(rd_addr), .rd_dout(dout_l2), .rd_valid(v_l2), .busy(b_l2));

  ram_dp_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW),
              .RD_LATENCY(2), .CLEAR_ON_RST(1'b0)) u_nc (
    .clk(clk), .rst(rst), .we(we), .wr_be(wr_be), .wr_addr(wr_addr), .wr_din(wr_din),
    .re(re), .rd_addr(rd_addr), .rd_dout(dout_nc), .rd_valid(v_nc), .busy(b_nc));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Advance one edge and sample 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
    if ((b_l1 && v_l1) || (b_l2 && v_l2)) busy_viol++;
  endtask

  task automatic idle();
    we = 1'b0;
    re = 1'b0;
    wr_be = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NBE-1:0] be);
    we = 1'b1; wr_addr = a; wr_din = d; wr_be = be;
    tick();
    idle();
  endtask

  // Single read; l1 answers after one edge, l2 and nc after two
  task automatic rd_check(input string name, input logic [AW-1:0] a,
                          input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                          input logic [DW-1:0] enc);
    re = 1'b1; rd_addr = a;
    tick();
    re = 1'b0;
    check({name, "_l1_valid"}, v_l1, 1);
    check({name, "_l1_data"}, dout_l1, e1);
    check({name, "_l2_early"}, v_l2, 0);
    tick();
    check({name, "_l1_strobe"}, v_l1, 0);
    check({name, "_l2_valid"}, v_l2, 1);
    check({name, "_l2_data"}, dout_l2, e2);
    check({name, "_nc_valid"}, v_nc, 1);
    check({name, "_nc_data"}, dout_nc, enc);
  endtask

  // Count samples with busy high, starting in the cycle rst was released
  task automatic count_busy(output int unsigned n1, output int unsigned n2);
    n1 = 0; n2 = 0;
    for (int i = 0; i < 40; i++) begin
      if (b_l1) n1++;
      if (b_l2) n2++;
      if (!b_l1 && !b_l2) break;
      tick();
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [NBE-1:0] be, input logic [AW-1:0] wa,
                              input logic [DW-1:0] d, input logic r, input logic [AW-1:0] ra,
                              input logic ev, input logic [DW-1:0] ed);
    vec_t v;
    v.we = w; v.be = be; v.waddr = wa; v.din = d;
    v.re = r; v.raddr = ra; v.ev = ev; v.ed = ed;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[21];
    int unsigned nb1, nb2, nc_hits, nc_at;
    logic [DW-1:0] nc_data, h1, h2, hnc, ped;
    logic          pev;

    tbl[0]  = mk(1, 2'b11, 4'd3, 16'hABCD, 0, 4'd0, 0, 16'h0000);
    tbl[1]  = mk(1, 2'b01, 4'd3, 16'h1234, 0, 4'd0, 0, 16'h0000);
    tbl[2]  = mk(0, 2'b00, 4'd0, 16'h0000, 1, 4'd3, 1, 16'hAB34);
    tbl[3]  = mk(1, 2'b11, 4'd5, 16'h1111, 0, 4'd0, 0, 16'h0000);
    tbl[4]  = mk(1, 2'b10, 4'd5, 16'h22FF, 1, 4'd5, 1, 16'h2211);
    tbl[5]  = mk(0, 2'b00, 4'd0, 16'h0000, 1, 4'd5, 1, 16'h2211);
    for (int k = 0; k < 4; k++) begin
      tbl[6 + k]  = mk(1, 2'b11, 4'(k), 16'h0100 + 16'(k), 0, 4'd0, 0, 16'h0000);
      tbl[10 + k] = mk(0, 2'b00, 4'd0, 16'h0000, 1, 4'(k), 1, 16'h0100 + 16'(k));
    end
    tbl[14] = mk(1, 2'b11, 4'd9, 16'h5A5A, 0, 4'd0, 0, 16'h0000);
    tbl[15] = mk(1, 2'b00, 4'd9, 16'hDEAD, 0, 4'd0, 0, 16'h0000);
    tbl[16] = mk(0, 2'b00, 4'd0, 16'h0000, 1, 4'd9, 1, 16'h5A5A);
    tbl[17] = mk(1, 2'b00, 4'd9, 16'hBEEF, 1, 4'd9, 1, 16'h5A5A);
    tbl[18] = mk(1, 2'b11, 4'd6, 16'hC3C3, 1, 4'd6, 1, 16'hC3C3);
    tbl[19] = mk(0, 2'b00, 4'd0, 16'h0000, 0, 4'd0, 0, 16'h0000);
    tbl[20] = mk(0, 2'b00, 4'd0, 16'h0000, 0, 4'd0, 0, 16'h0000);

    // Reset values
    tick(); tick();
    check("rst_busy_l1", b_l1, 1);
    check("rst_busy_l2", b_l2, 1);
    check("rst_busy_nc", b_nc, 0);
    check("rst_valid_l1", v_l1, 0);
    check("rst_valid_l2", v_l2, 0);
    check("rst_valid_nc", v_nc, 0);
    check("rst_dout_l1", dout_l1, 0);
    check("rst_dout_l2", dout_l2, 0);
    check("rst_dout_nc", dout_nc, 0);

    // Busy gating: write+read addr 7 during the clear; only nc accepts it
    rst = 1'b0;
    we = 1'b1; wr_be = 2'b11; wr_addr = 4'd7; wr_din = 16'h7777; re = 1'b1; rd_addr = 4'd7;
    nb1 = 0; nb2 = 0; nc_hits = 0; nc_at = 0; nc_data = '0;
    for (int i = 0; i < 40; i++) begin
      if (b_l1) nb1++;
      if (b_l2) nb2++;
      if (v_nc) begin nc_hits++; nc_at = i; nc_data = dout_nc; end
      if (!b_l1 && !b_l2) break;
      tick();
      idle();
    end
    check("busy_len_first_l1", nb1, 16);
    check("busy_len_first_l2", nb2, 16);
    check("nc_during_clear_hits", nc_hits, 1);
    check("nc_during_clear_at", nc_at, 2);
    check("nc_during_clear_data", nc_data, 16'h7777);
    rd_check("gated_wr_addr7", 4'd7, 16'h0000, 16'h0000, 16'h7777);

    // Pre-fill with 0xFFFF, reset, expect clear (nc retains)
    for (int a = 0; a < 16; a++) wr(4'(a), 16'hFFFF, 2'b11);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    count_busy(nb1, nb2);
    check("busy_len_l1", nb1, 16);
    check("busy_len_l2", nb2, 16);
    check("busy_nc_never", b_nc, 0);
    for (int a = 0; a < 17; a++) begin
      re = (a < 16);
      rd_addr = 4'(a);
      tick();
      if (a < 16) begin
        check($sformatf("clr_l1_valid_a%0d", a), v_l1, 1);
        check($sformatf("clr_l1_data_a%0d", a), dout_l1, 16'h0000);
      end else begin
        check("clr_l1_valid_end", v_l1, 0);
      end
      if (a > 0) begin
        check($sformatf("clr_l2_data_a%0d", a - 1), {15'd0, v_l2, dout_l2}, {16'd1, 16'h0000});
        check($sformatf("ret_nc_data_a%0d", a - 1), {15'd0, v_nc, dout_nc}, {16'd1, 16'hFFFF});
      end else begin
        check("clr_l2_valid_first", v_l2, 0);
      end
    end
    idle();

    // Table: l1 result one sample after its row, l2/nc two; rd_dout holds between reads
    h1 = 16'h0000; h2 = 16'h0000; hnc = 16'hFFFF; pev = 1'b0; ped = '0;
    for (int i = 0; i < 21; i++) begin
      we = tbl[i].we; wr_be = tbl[i].be; wr_addr = tbl[i].waddr; wr_din = tbl[i].din;
      re = tbl[i].re; rd_addr = tbl[i].raddr;
      tick();
      if (tbl[i].ev) h1 = tbl[i].ed;
      if (pev) begin h2 = ped; hnc = ped; end
      check($sformatf("tbl%0d_l1_valid", i), v_l1, tbl[i].ev);
      check($sformatf("tbl%0d_l1_data", i), dout_l1, h1);
      check($sformatf("tbl%0d_l2_valid", i), v_l2, pev);
      check($sformatf("tbl%0d_l2_data", i), dout_l2, h2);
      check($sformatf("tbl%0d_nc_valid", i), v_nc, pev);
      check($sformatf("tbl%0d_nc_data", i), dout_nc, hnc);
      pev = tbl[i].ev; ped = tbl[i].ed;
    end
    idle();

    // Reset in the middle of a latency-2 read
    wr(4'd4, 16'h4444, 2'b11);
    re = 1'b1; rd_addr = 4'd4;
    tick();
    re = 1'b0;
    check("midrst_l1_valid", v_l1, 1);
    check("midrst_l1_data", dout_l1, 16'h4444);
    rst = 1'b1;
    tick();
    check("midrst_l2_valid", v_l2, 0);
    check("midrst_l2_data", dout_l2, 16'h0000);
    check("midrst_nc_valid", v_nc, 0);
    check("midrst_nc_data", dout_nc, 16'h0000);
    check("midrst_l1_flushed", {v_l1, dout_l1}, 17'h0);
    tick();
    rst = 1'b0;
    re = 1'b1; rd_addr = 4'd4;
    tick();
    re = 1'b0;
    check("midrst_nc_early", v_nc, 0);
    tick();
    check("midrst_nc_valid_after", v_nc, 1);
    check("midrst_nc_retained", dout_nc, 16'h4444);
    check("midrst_l2_dropped", v_l2, 0);
    for (int i = 0; i < 40; i++) begin
      if (!b_l1 && !b_l2) break;
      tick();
    end
    check("midrst_busy_release", {b_l1, b_l2}, 0);
    rd_check("midrst_cleared_addr4", 4'd4, 16'h0000, 16'h0000, 16'h4444);

    check("valid_while_busy", busy_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
